mat_stream_loader: RTL and testbench



---
 rtl/mat_stream_loader_pkg.sv | 19 +
 rtl/mat_stream_loader_if.sv | 31 +++
 rtl/mat_stream_loader.sv | 111 +++++++++++
 tb/tb_mat_stream_loader.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mat_stream_loader_pkg.sv
// Shared sizes and types for the matrix stream loader and its mat_mul neighbour.
// Latency: none, types and constants only.
// Backpressure: none, types and constants only.
package mat_pkg;

  localparam int N     = 4;
  localparam int W_IN  = 8;
  localparam int W_OUT = 32;
  localparam int LAT   = $clog2(N) + 1;
  localparam int NN    = N * N;

  typedef logic signed [W_IN-1:0]  elem_t;
  typedef logic signed [W_OUT-1:0] acc_t;
  typedef elem_t [N-1:0][N-1:0]    mat_in_t;
  typedef acc_t  [N-1:0][N-1:0]    mat_out_t;

  typedef enum logic [1:0] {LOAD_A, LOAD_B, COMPUTE, WAIT_OUT} state_t;

endpackage

// File: rtl/mat_stream_loader_if.sv
// Bundle of the element stream, mat_mul operand/product wires and the result port.
// Latency: none, wiring only.
// Backpressure: s_ready/s_valid on the stream, out_valid/out_ready on the result.
interface mat_stream_loader_if import mat_pkg::*; ();

  elem_t    s_data;
  logic     s_valid;
  logic     s_last;
  logic     s_ready;
  mat_in_t  matrix_1;
  mat_in_t  matrix_2;
  logic     cen;
  mat_out_t mm_result;
  mat_out_t out_data;
  logic     out_valid;
  logic     out_ready;
  logic     err;

  // Loader side: consumes the stream and the product, drives operands and result.
  modport slave (
    input  s_data, s_valid, s_last, mm_result, out_ready,
    output s_ready, matrix_1, matrix_2, cen, out_data, out_valid, err
  );

  // Environment side: feeds elements, provides the product, takes the result.
  modport master (
    output s_data, s_valid, s_last, mm_result, out_ready,
    input  s_ready, matrix_1, matrix_2, cen, out_data, out_valid, err
  );

endinterface

// File: rtl/mat_stream_loader.sv
// Loads matrix_1 then matrix_2 from a row-major element stream, holds them for mat_mul, captures the product.
// Latency: product captured on the LAT+1-th edge after the last B element is accepted (later if the result port is full).
// Backpressure: s_ready low outside LOAD_A/LOAD_B; a full, unconsumed result register parks the job in WAIT_OUT.
module mat_stream_loader import mat_pkg::*; (
  input  logic              clk,
  input  logic              rst,
  mat_stream_loader_if.slave io
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(LAT + 1);

  state_t         state;
  logic [IW-1:0]  row;
  logic [IW-1:0]  col;
  logic [IW-1:0]  row_nxt;
  logic [IW-1:0]  col_nxt;
  logic [CW-1:0]  lat_cnt;
  mat_in_t        m1;
  mat_in_t        m2;
  mat_out_t       res;
  logic           res_vld;
  logic           err_r;
  logic           xfer;
  logic           at_last;
  logic           res_due;
  logic           capture;

  assign xfer    = io.s_valid && io.s_ready;
  assign at_last = (row == IW'(N - 1)) && (col == IW'(N - 1));
  // Product is ready once the counter has seen LAT edges; WAIT_OUT only exists while it is pending.
  assign res_due = ((state == COMPUTE) && (lat_cnt == CW'(LAT))) || (state == WAIT_OUT);
  assign capture = res_due && (!res_vld || io.out_ready);

  assign io.s_ready   = (state == LOAD_A) || (state == LOAD_B);
  assign io.cen       = 1'b1;
  assign io.matrix_1  = m1;
  assign io.matrix_2  = m2;
  assign io.out_data  = res;
  assign io.out_valid = res_vld;
  assign io.err       = err_r;

  // Next row/column position in row-major order, wrapping after the last element.
  always_comb begin
    col_nxt = col + IW'(1);
    row_nxt = row;
    if (col == IW'(N - 1)) begin
      col_nxt = '0;
      row_nxt = at_last ? '0 : row + IW'(1);
    end
  end

  // Load/compute/output FSM with its element index, latency counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= LOAD_A;
      row     <= '0;
      col     <= '0;
      lat_cnt <= '0;
      m1      <= '0;
      m2      <= '0;
      res     <= '0;
      res_vld <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      // s_last must mark exactly the final B element; framing is still tracked by count only.
      if (xfer && (io.s_last != ((state == LOAD_B) && at_last)))
        err_r <= 1'b1;

      if (capture) begin
        res     <= io.mm_result;
        res_vld <= 1'b1;
      end else if (io.out_ready) begin
        res_vld <= 1'b0;
      end

      case (state)
        LOAD_A: begin
          if (xfer) begin
            m1[row][col] <= io.s_data;
            row <= row_nxt;
            col <= col_nxt;
            if (at_last) state <= LOAD_B;
          end
        end
        LOAD_B: begin
          if (xfer) begin
            m2[row][col] <= io.s_data;
            row <= row_nxt;
            col <= col_nxt;
            if (at_last) begin
              state   <= COMPUTE;
              lat_cnt <= '0;
            end
          end
        end
        COMPUTE: begin
          if (lat_cnt == CW'(LAT))
            state <= capture ? LOAD_A : WAIT_OUT;
          else
            lat_cnt <= lat_cnt + CW'(1);
        end
        WAIT_OUT: begin
          if (capture) state <= LOAD_A;
        end
        default: state <= LOAD_A;
      endcase
    end
  end

endmodule

// File: tb/tb_mat_stream_loader.sv
// Bench for mat_stream_loader with a behavioural mat_mul neighbour and a plain-arithmetic product reference.
// Latency: checks result appearance LAT+1 edges after the last accepted element.
// Backpressure: exercises s_valid bubbles and a stalled result port.
module tb_mat_stream_loader;
  import mat_pkg::*;

  localparam int TOT = 2 * NN;

  typedef struct {
    int a_kind;
    int b_kind;
    int bubble_pct;
    int last_pos;
    bit exp_err;
    bit has_c00;
    int exp_c00;
  } vec_t;

  logic clk = 1'b0;
  logic rst;

  mat_stream_loader_if bus ();

  mat_stream_loader dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  always #5 clk = ~clk;

  // mat_mul stand-in: full product of its operands, delivered LAT edges later.
  mat_out_t mm_pipe [LAT];

  function automatic mat_out_t mm_product(input mat_in_t a, input mat_in_t b);
    mat_out_t r;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        int acc;
        acc = 0;
        for (int k = 0; k < N; k++)
          acc += int'($signed(a[i][k])) * int'($signed(b[k][j]));
        r[i][j] = acc_t'(acc);
      end
    return r;
  endfunction

  always @(posedge clk) begin
    if (bus.cen) begin
      mm_pipe[0] <= mm_product(bus.matrix_1, bus.matrix_2);
      for (int i = 1; i < LAT; i++) mm_pipe[i] <= mm_pipe[i-1];
    end
  end

  assign bus.mm_result = mm_pipe[LAT-1];

  int a_ref [NN];
  int b_ref [NN];
  int exp_prod [NN];
  int prev_prod [NN];
  bit err_model;
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  task automatic check_out(input string name, input int expv [NN]);
    int bad;
    int got;
    bad = -1;
    got = 0;
    checks++;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        if (bad < 0 && int'($signed(bus.out_data[i][j])) != expv[i*N+j]) begin
          bad = i * N + j;
          got = int'($signed(bus.out_data[i][j]));
        end
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s: element %0d got %0d, expected %0d", name, bad, got, expv[bad]);
    end
  endtask

  task automatic fill(input int kind, output int m [NN]);
    for (int e = 0; e < NN; e++)
      case (kind)
        0:       m[e] = (e / N == e % N) ? 1 : 0;
        1:       m[e] = e + 1;
        2:       m[e] = -128;
        4:       m[e] = ($urandom_range(1) != 0) ? 127 : -128;
        default: m[e] = int'($urandom_range(255)) - 128;
      endcase
  endtask

  // Reference product from the stimulus values, row-major.
  task automatic compute_ref();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        int s;
        s = 0;
        for (int k = 0; k < N; k++) s += a_ref[i*N+k] * b_ref[k*N+j];
        exp_prod[i*N+j] = s;
      end
  endtask

  task automatic do_reset(input bit full_check);
    rst = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_last = 1'b0;
    bus.s_data = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    err_model = 1'b0;
    if (full_check) begin
      check("reset_s_ready", bus.s_ready, 1);
      check("reset_out_valid", bus.out_valid, 0);
      check("reset_err", bus.err, 0);
      check("reset_cen", bus.cen, 1);
      check("reset_matrix_1_nonzero", longint'(|bus.matrix_1), 0);
      check("reset_matrix_2_nonzero", longint'(|bus.matrix_2), 0);
      check("reset_out_data_nonzero", longint'(|bus.out_data), 0);
    end
  endtask

  // Streams elements 0..n_elems-1 (A then B), with random s_valid bubbles; checks err after every transfer.
  task automatic stream_job(input int bubble_pct, input int last_pos, input int n_elems);
    for (int e = 0; e < n_elems; e++) begin
      int v;
      bit lst;
      bit ok;
      v = (e < NN) ? a_ref[e] : b_ref[e-NN];
      lst = (e == last_pos);
      ok = 1'b0;
      if (int'($urandom_range(99)) < bubble_pct) begin
        bus.s_valid = 1'b0;
        bus.s_data = elem_t'($urandom);
        bus.s_last = ($urandom_range(1) != 0);
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      bus.s_valid = 1'b1;
      bus.s_data = elem_t'(v);
      bus.s_last = lst;
      for (int n = 0; n < 40 && !ok; n++) begin
        ok = bus.s_ready;
        @(posedge clk);
        #1;
      end
      bus.s_valid = 1'b0;
      bus.s_last = 1'b0;
      if (!ok) begin
        checks++;
        errors++;
        $display("FAIL stream_accept_timeout: element %0d got no s_ready, expected accept within 40 cycles", e);
      end else begin
        err_model = err_model | (lst != (e == TOT - 1));
        check("err_after_element", bus.err, longint'(err_model));
      end
    end
  endtask

  // Waits for the result (out_ready held high), checks busy s_ready, latency, data and the consume edge.
  task automatic collect(input string name);
    int n;
    n = 0;
    while (!bus.out_valid && n < 20) begin
      check({name, "_s_ready_while_busy"}, bus.s_ready, 0);
      @(posedge clk);
      #1;
      n++;
    end
    check({name, "_latency"}, n, LAT + 1);
    check({name, "_s_ready_after_capture"}, bus.s_ready, 1);
    check_out({name, "_data"}, exp_prod);
    check({name, "_err"}, bus.err, longint'(err_model));
    @(posedge clk);
    #1;
    check({name, "_out_valid_consumed"}, bus.out_valid, 0);
  endtask

  vec_t vecs [8];

  initial begin
    int n;

    vecs[0] = '{0, 1, 0,  TOT - 1, 1'b0, 1'b1, 1};
    vecs[1] = '{2, 2, 0,  TOT - 1, 1'b0, 1'b1, 65536};
    vecs[2] = '{3, 3, 40, TOT - 1, 1'b0, 1'b0, 0};
    vecs[3] = '{4, 4, 30, TOT - 1, 1'b0, 1'b0, 0};
    vecs[4] = '{0, 1, 25, 10,      1'b1, 1'b1, 1};
    vecs[5] = '{3, 3, 10, -1,      1'b1, 1'b0, 0};
    vecs[6] = '{1, 0, 50, TOT - 1, 1'b0, 1'b1, 1};
    vecs[7] = '{3, 0, 0,  5,       1'b1, 1'b0, 0};

    // Table: each vector is an independent job from reset.
    for (int i = 0; i < 8; i++) begin
      do_reset(i == 0);
      fill(vecs[i].a_kind, a_ref);
      fill(vecs[i].b_kind, b_ref);
      compute_ref();
      stream_job(vecs[i].bubble_pct, vecs[i].last_pos, TOT);
      collect("vec");
      check("vec_err_final", bus.err, longint'(vecs[i].exp_err));
      if (vecs[i].has_c00)
        check("vec_c00", int'($signed(bus.out_data[0][0])), vecs[i].exp_c00);
    end

    // Back-to-back random jobs without reset; matrix_1 is rewritten while the old product sits in out_data.
    do_reset(1'b0);
    for (int r = 0; r < 8; r++) begin
      fill(3, a_ref);
      fill(3, b_ref);
      compute_ref();
      stream_job(int'($urandom_range(60)), TOT - 1, TOT);
      collect("b2b");
    end

    // Stalled result port: second job parks in WAIT_OUT, then one out_ready cycle swaps results.
    do_reset(1'b0);
    bus.out_ready = 1'b0;
    fill(3, a_ref);
    fill(3, b_ref);
    compute_ref();
    stream_job(20, TOT - 1, TOT);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("stall_first_latency", n, LAT + 1);
    check_out("stall_first_data", exp_prod);
    prev_prod = exp_prod;
    fill(3, a_ref);
    fill(3, b_ref);
    compute_ref();
    stream_job(0, TOT - 1, TOT);
    repeat (LAT + 3) @(posedge clk);
    #1;
    check("stall_wait_s_ready", bus.s_ready, 0);
    check("stall_wait_out_valid", bus.out_valid, 1);
    check_out("stall_wait_data_stable", prev_prod);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("stall_swap_out_valid", bus.out_valid, 1);
    check_out("stall_swap_data", exp_prod);
    check("stall_swap_s_ready", bus.s_ready, 1);
    @(posedge clk);
    #1;
    check("stall_hold_out_valid", bus.out_valid, 1);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("stall_release_out_valid", bus.out_valid, 0);

    // Asynchronous reset between edges in the middle of LOAD_B, with err already set.
    fill(3, a_ref);
    fill(3, b_ref);
    stream_job(0, 3, NN + 5);
    check("midrst_err_before", bus.err, 1);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_matrix_1_nonzero", longint'(|bus.matrix_1), 0);
    check("midrst_matrix_2_nonzero", longint'(|bus.matrix_2), 0);
    check("midrst_out_data_nonzero", longint'(|bus.out_data), 0);
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_err", bus.err, 0);
    #2;
    rst = 1'b0;
    err_model = 1'b0;
    @(posedge clk);
    #1;
    fill(3, a_ref);
    fill(3, b_ref);
    compute_ref();
    stream_job(15, TOT - 1, TOT);
    collect("midrst_fresh");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
